// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: FSM encodings and parameter defaults.
package int_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_ACK_TIMEOUT = 15;

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchronizer for the async interrupt pin, followed by a rising-edge detector.
module int_sync
    import int_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // prev_q clears on reset, so a pin already high at release counts as one edge
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending latch, request/service FSM, ack-timeout counter, sticky flags.
module int_ctrl
    import int_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ext_int,
    input  logic int_enable,
    input  logic int_hold,
    input  logic int_clr,
    input  logic rti_done,
    output logic intr,
    output logic in_service,
    output logic int_pending,
    output logic int_overrun,
    output logic int_err
);

    localparam logic [CNT_W-1:0] TMO      = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic             rise;
    logic             issue;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             req_pending_q, req_pending_d;
    logic             int_overrun_q, int_overrun_d;
    logic             int_err_q, int_err_d;
    logic             intr_q, intr_d;
    logic             in_service_q, in_service_d;

    int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ext_int),
        .rise     (rise)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        int_err_d  = int_err_q;
        issue      = 1'b0;
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                if (req_pending_q && int_enable && !int_hold) begin
                    state_d = S_REQ;
                    issue   = 1'b1;
                end
            end
            S_REQ: begin
                if (int_clr) begin
                    state_d = S_SERVICE;
                end else if (wait_cnt_q != TMO) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_q == TMO_LAST) int_err_d = 1'b1;
                end
            end
            S_SERVICE: begin
                if (rti_done) state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
            end
        endcase

        // A fresh edge in the issue cycle re-arms the latch rather than counting as overrun
        req_pending_d = rise | (req_pending_q & ~issue);
        int_overrun_d = int_overrun_q | (rise & req_pending_q & ~issue);

        // Outputs registered from the next state so fetch sees clean flop outputs
        intr_d       = (state_d == S_REQ);
        in_service_d = (state_d == S_SERVICE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            req_pending_q <= 1'b0;
            int_overrun_q <= 1'b0;
            int_err_q     <= 1'b0;
            intr_q        <= 1'b0;
            in_service_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            req_pending_q <= req_pending_d;
            int_overrun_q <= int_overrun_d;
            int_err_q     <= int_err_d;
            intr_q        <= intr_d;
            in_service_q  <= in_service_d;
        end
    end

    assign intr        = intr_q;
    assign in_service  = in_service_q;
    assign int_pending = req_pending_q;
    assign int_overrun = int_overrun_q;
    assign int_err     = int_err_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset/latency sequence, vector table, then timeout and async reset.
module tb_int_ctrl;

    logic clk = 1'b0;
    logic reset, ext_int, int_enable, int_hold, int_clr, rti_done;
    logic intr, in_service, int_pending, int_overrun, int_err;

    int n_chk  = 0;
    int n_fail = 0;

    // in  = {ext_int, int_enable, int_hold, int_clr, rti_done}
    // exp = {intr, in_service, int_pending, int_overrun, int_err}
    typedef struct packed {
        logic [4:0] in;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    int_ctrl #(.SYNC_STAGES(2), .ACK_TIMEOUT(4), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ext_int     (ext_int),
        .int_enable  (int_enable),
        .int_hold    (int_hold),
        .int_clr     (int_clr),
        .rti_done    (rti_done),
        .intr        (intr),
        .in_service  (in_service),
        .int_pending (int_pending),
        .int_overrun (int_overrun),
        .int_err     (int_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [4:0] exp);
        chk({name, ".intr"},        intr,        exp[4]);
        chk({name, ".in_service"},  in_service,  exp[3]);
        chk({name, ".int_pending"}, int_pending, exp[2]);
        chk({name, ".int_overrun"}, int_overrun, exp[1]);
        chk({name, ".int_err"},     int_err,     exp[0]);
    endtask

    task automatic drive(input logic [4:0] in);
        {ext_int, int_enable, int_hold, int_clr, rti_done} = in;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [4:0] in, input logic [4:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        // Vector table: handshake, nested edge, overrun, hold/enable gating
        for (int i = 0; i < 3; i++) add(5'b01000, 5'b00000);
        add(5'b11000, 5'b00000);
        add(5'b11000, 5'b00000);
        add(5'b11000, 5'b00100);
        add(5'b11000, 5'b10000);
        for (int i = 0; i < 3; i++) add(5'b01000, 5'b10000);
        add(5'b01010, 5'b01000);
        add(5'b01000, 5'b01000);
        add(5'b11000, 5'b01000);
        add(5'b01000, 5'b01000);
        add(5'b01000, 5'b01100);
        add(5'b01001, 5'b00100);
        add(5'b01000, 5'b10000);
        add(5'b01010, 5'b01000);
        add(5'b11000, 5'b01000);
        add(5'b01000, 5'b01000);
        add(5'b11000, 5'b01100);
        add(5'b01000, 5'b01100);
        add(5'b11000, 5'b01110);
        add(5'b01000, 5'b01110);
        add(5'b01000, 5'b01110);
        add(5'b01001, 5'b00110);
        add(5'b01000, 5'b10010);
        add(5'b01010, 5'b01010);
        add(5'b01001, 5'b00010);
        add(5'b01000, 5'b00010);
        add(5'b11100, 5'b00010);
        add(5'b01100, 5'b00010);
        add(5'b01100, 5'b00110);
        for (int i = 0; i < 10; i++) add(5'b01100, 5'b00110);
        add(5'b01000, 5'b10010);
        add(5'b00100, 5'b10010);
        add(5'b00000, 5'b10010);
        add(5'b00010, 5'b01010);
        add(5'b01001, 5'b00010);

        // Reset held with pin high: everything stays 0
        reset = 1'b0;
        drive(5'b11000);
        step();
        step();
        step();
        chk_all("rst_hold", 5'b00000);

        // Release away from an edge; intr appears 3 edges after the first sampling edge
        reset = 1'b1;
        step();
        chk_all("lat_e0", 5'b00000);
        step();
        chk_all("lat_e1", 5'b00000);
        step();
        chk_all("lat_e2", 5'b00100);
        step();
        chk_all("lat_e3", 5'b10000);
        drive(5'b11010);
        step();
        chk_all("lat_ack", 5'b01000);
        drive(5'b11001);
        step();
        chk_all("lat_rti", 5'b00000);
        drive(5'b11000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("level_once%0d", i), 5'b00000);
        end

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Acknowledge timeout with ACK_TIMEOUT=4
        drive(5'b11000);
        step();
        drive(5'b01000);
        step();
        step();
        chk_all("tmo_pend", 5'b00110);
        step();
        chk_all("tmo_req", 5'b10010);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_all($sformatf("tmo_wait%0d", i), 5'b10010);
        end
        step();
        chk_all("tmo_err", 5'b10011);
        step();
        chk_all("tmo_sat", 5'b10011);
        drive(5'b01010);
        step();
        chk_all("tmo_ack", 5'b01011);

        // Edge during service, then async reset drops state and the pending request
        drive(5'b11000);
        step();
        drive(5'b01000);
        step();
        step();
        chk_all("svc_pend", 5'b01111);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 5'b00000);
        step();
        reset = 1'b1;
        step();
        chk_all("post_rst", 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller feeding the fetch-stage control unit. It synchronizes an asynchronous external interrupt pin, latches one pending request, and raises a registered `intr` toward fetch. It holds `intr` until fetch acknowledges with `int_clr`, then masks further interrupts until the handler's RTI retires. It sits between the I/O pad and fetch control, and takes an RTI-retired pulse from the writeback stage.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on `ext_int`; must be ≥2.
- ACK_TIMEOUT, 15: cycles in S_REQ without `int_clr` before `int_err` is set; must be ≥1.
- CNT_W, 4: width of the acknowledge-wait counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- ext_int  in  1  external interrupt pin, asynchronous, rising-edge sensitive
- int_enable  in  1  global interrupt enable
- int_hold  in  1  fetch busy, e.g. mid two-byte instruction or stalled; blocks issue
- int_clr  in  1  acknowledge pulse from fetch control
- rti_done  in  1  one-cycle pulse when RTI retires
- intr  out  1  interrupt request to fetch; flop output only
- in_service  out  1  a handler is executing
- int_pending  out  1  a request is latched and not yet issued
- int_overrun  out  1  sticky: an edge was dropped because a request was already pending
- int_err  out  1  sticky: acknowledge timeout

## Operation
- Synchronizer: `ext_int` passes through SYNC_STAGES flops. `rise = sync_last & ~sync_prev`.
- Pending latch: `rise` sets `req_pending`. It clears on the edge where state moves S_IDLE→S_REQ.
  - `rise` while `req_pending` is already 1 sets `int_overrun`; the request is dropped.
  - If set and clear occur in the same cycle, set wins only when `rise` comes from a new edge. The old request is consumed and the new one stays pending.
- State machine, encoded S_IDLE=0, S_REQ=1, S_SERVICE=2:
  - S_IDLE: if `req_pending & int_enable & ~int_hold`, go to S_REQ. Otherwise stay.
  - S_REQ: `intr=1`. If `int_clr`, go to S_SERVICE. Otherwise stay and increment `wait_cnt`.
    - When `wait_cnt` reaches ACK_TIMEOUT, set `int_err` and saturate the counter. Stay in S_REQ.
    - `intr` is never retracted once raised, even if `int_enable` drops or `int_hold` rises.
  - S_SERVICE: `in_service=1`. New edges latch into `req_pending` but are not issued. If `rti_done`, go to S_IDLE.
- Ignored inputs: `int_clr` outside S_REQ; `rti_done` outside S_SERVICE.
- Output decode: `intr = (state==S_REQ)`, `in_service = (state==S_SERVICE)`, `int_pending = req_pending`. All come straight from flops, because fetch uses `intr` as a reset-like force and it must be glitch-free.
- Unused state encoding 3: go to S_IDLE.

## Timing
- Reset, asynchronous: state=S_IDLE, all sync flops 0, `req_pending`=0, `wait_cnt`=0. Therefore `intr`, `in_service`, `int_pending`, `int_overrun` and `int_err` are all 0.
- Reset asserted mid-service or mid-request drops everything, including any pending request.
- Pin-to-intr latency, with `ext_int` first high before edge E0, enabled and not held:
  - `req_pending`=1 after edge E(SYNC_STAGES).
  - `intr`=1 after edge E(SYNC_STAGES+1). This is 3 edges after E0 for the default.
- Acknowledge: `int_clr` sampled high at edge Ek (state S_REQ) gives `intr`=0 and `in_service`=1 after Ek.
- Return: `rti_done` at edge Em gives `in_service`=0 after Em. If a request is pending, `intr`=1 after Em+1, so there is a minimum of one S_IDLE cycle.
- `wait_cnt` clears on entry to S_REQ. `int_err` is set on the edge where `wait_cnt` goes from ACK_TIMEOUT-1 to ACK_TIMEOUT.
- A level held high on `ext_int` produces exactly one request.

## Structure
- Shared package `int_pkg`: state encodings S_IDLE, S_REQ, S_SERVICE, and the default SYNC_STAGES and ACK_TIMEOUT values.
- Sub-module `int_sync`: parameterized synchronizer plus rising-edge detector. It takes clk, reset, the async input, and outputs `rise`.
- Top `int_ctrl`: pending latch, state machine, counter and sticky flags.

## Test plan
- Reset: hold `reset`=0 with `ext_int`=1 → all outputs 0; release → `intr`=1 exactly 3 edges after the first sampling edge.
- Basic handshake: pulse `ext_int` high for 4 cycles, no `int_clr` for 5 cycles → `intr` stays high; `int_clr` pulse → next cycle `intr`=0, `in_service`=1; `rti_done` → `in_service`=0, `intr` stays 0.
- Nested edge: one edge during S_SERVICE → `int_pending`=1 and `intr`=0; `rti_done` → one idle cycle, then `intr`=1 and `int_pending`=0.
- Overrun: three edges during S_SERVICE → `int_overrun`=1 and sticky; after RTI only one `intr` is issued.
- Gating: `int_hold`=1 with a request pending → `intr` stays 0 for 10 cycles; drop `int_hold` → `intr`=1 after the next edge. Then drop `int_enable` in S_REQ → `intr` remains 1.
- Timeout and reset: ACK_TIMEOUT=4, no `int_clr` → `int_err`=1 after the 4th S_REQ cycle and `intr` still 1; `int_clr` is then accepted normally; assert `reset` in S_SERVICE → all outputs 0 immediately.
